set_assoc_cache: RTL and testbench
==================================

# set_assoc_cache

Parametrised N-way set-associative, write-back, write-allocate cache with integrated tag/valid/dirty/LRU storage and miss-handling FSM. Sits between a single-word CPU load/store port and a line-wide lower-memory port. Generalises the fixed 4-way line store: way count, set count, line and word width are parameters. Adds tag compare, true-LRU replacement, dirty writeback and refill sequencing.

## Interface
- `WAYS`, 4, associativity (≥2, power of two)
- `SETS`, 64, sets per way (power of two)
- `LINE_BYTES`, 64, bytes per line (power of two, ≥ WORD_BITS/8)
- `ADDR_BITS`, 32, byte address width
- `WORD_BITS`, 32, CPU data width
- Derived: OFF=log2(LINE_BYTES), IDX=log2(SETS), TAG=ADDR_BITS−IDX−OFF, LINE=LINE_BYTES*8
- `clk` in 1 — single clock, all logic posedge
- `rst` in 1 — synchronous, active-high
- `req_valid` in 1 — CPU request
- `req_ready` out 1 — high only in IDLE
- `req_write` in 1 — 1 store, 0 load
- `req_addr` in ADDR_BITS — byte address; low log2(WORD_BITS/8) bits ignored
- `req_wdata` in WORD_BITS — store data
- `req_wstrb` in WORD_BITS/8 — byte enables
- `resp_valid` out 1 — one-cycle pulse, no backpressure
- `resp_rdata` out WORD_BITS — load data (stores: word after merge)
- `resp_hit` out 1 — 1 if the lookup hit
- `mem_req_valid` out 1 — lower-memory request
- `mem_req_ready` in 1 — lower memory accepts
- `mem_req_write` out 1 — 1 writeback, 0 refill read
- `mem_req_addr` out ADDR_BITS — line-aligned (low OFF bits 0)
- `mem_wdata` out LINE — victim line
- `mem_resp_valid` in 1 — refill data valid
- `mem_rdata` in LINE — refill line
- `hit_count`, `miss_count` out 32 — see Configuration

## Operation
- Storage per set per way: valid, dirty, TAG-bit tag, LINE-bit data, log2(WAYS)-bit age.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: req_ready=1; on req_valid, capture write/addr/wdata/wstrb → LOOKUP.
- LOOKUP: compare captured tag against all valid ways of the indexed set. More than one matching way is an illegal condition that cannot arise.
  - Hit: load reads the word at the offset; store merges bytes per wstrb and sets dirty. Update LRU → RESPOND.
  - Miss, victim clean or invalid → REFILL; victim valid and dirty → WRITEBACK.
- Victim: lowest-index invalid way; if all valid, the way with age WAYS−1.
- WRITEBACK: mem_req_valid=1, write=1, addr={victim tag, idx, 0}, wdata=victim line, all held stable until mem_req_ready → REFILL.
- REFILL: mem_req_valid=1, write=0, addr={req tag, idx, 0} until mem_req_ready. Then wait for mem_resp_valid. Install the line in the victim way with valid=1 and tag set. A store merges its word into the incoming line and sets dirty=1; a load clears dirty. Update LRU → RESPOND.
- RESPOND: resp_valid=1 and resp_hit latched; → IDLE.
- LRU update on access to way w with age a: age[w]←0; every way with age<a increments. Ages remain a permutation of 0..WAYS−1.
- mem_resp_valid outside the REFILL data-wait is ignored.

## Timing
- Reset (rst=1 at a clock edge): state IDLE; all valid/dirty cleared; age[w]=w; req_ready=1 in the following cycle; resp_valid=0, resp_hit=0, resp_rdata=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_wdata=0, counters=0. Data arrays are not reset.
- Reset mid-operation aborts immediately: mem_req_valid drops the next cycle and no install occurs. Lower memory must be reset together with this block.
- Hit latency: accept at edge N, LOOKUP N+1, resp_valid during cycle N+2.
- Clean miss: resp_valid 1 cycle after the edge where mem_resp_valid is sampled.
- Dirty miss: writeback handshake, then refill request on the cycle after writeback acceptance.
- Back-to-back hits: one request per 3 cycles (IDLE, LOOKUP, RESPOND).
- A store followed by a load to the same word returns the new data; no bypass path is needed because access is serialised.

## Configuration
- `CACHE_PERF_CNT_EN` defined: hit_count and miss_count increment once per LOOKUP. They are 32-bit wrap-around counters, cleared by rst.
- Undefined: both outputs tied to 0 and no counter flops are present.

## Test plan
- After reset, load 0x0000_1000, mem returns line with word0=0xDEAD_BEEF -> one refill read at 0x1000, resp_rdata=0xDEAD_BEEF, resp_hit=0; repeat load -> resp_hit=1, no mem request, resp_valid 2 cycles after accept.
- Store 0x1234_5678 wstrb=0011 to hit word holding 0xDEAD_BEEF -> resp_rdata=0xDEAD_5678; line dirty.
- Fill one set with WAYS+1 distinct tags (dirty first way) -> the first-loaded way is evicted, writeback at its address carrying the stored data, then refill of the new tag.
- Access ways in order 0,1,2,3 then 0 then a new tag -> way 1 is the victim.
- Hold mem_req_ready=0 for 10 cycles during WRITEBACK -> mem_req_valid/addr/wdata stable; assert rst mid-REFILL -> next cycle IDLE, mem_req_valid=0, subsequent load misses.
- With CACHE_PERF_CNT_EN: 3 misses + 5 hits -> miss_count=3, hit_count=5; without it both read 0.

Source files
------------

// File: rtl/set_assoc_cache_if.sv
// CPU word port and lower-memory line port of set_assoc_cache, plus its perf counters.
// slave = cache side, master = CPU/memory side; req_* is valid/ready, resp_* is an unthrottled pulse.
`timescale 1ns/1ps
interface set_assoc_cache_if #(
   parameter int ADDR_BITS = 32,
   parameter int WORD_BITS = 32,
   parameter int LINE_BITS = 512
);
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_write;
   logic [ADDR_BITS-1:0]   req_addr;
   logic [WORD_BITS-1:0]   req_wdata;
   logic [WORD_BITS/8-1:0] req_wstrb;
   logic                   resp_valid;
   logic [WORD_BITS-1:0]   resp_rdata;
   logic                   resp_hit;
   logic                   mem_req_valid;
   logic                   mem_req_ready;
   logic                   mem_req_write;
   logic [ADDR_BITS-1:0]   mem_req_addr;
   logic [LINE_BITS-1:0]   mem_wdata;
   logic                   mem_resp_valid;
   logic [LINE_BITS-1:0]   mem_rdata;
   logic [31:0]            hit_count;
   logic [31:0]            miss_count;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_hit,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
      output hit_count, miss_count
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output mem_req_ready, mem_resp_valid, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_hit,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
      input  hit_count, miss_count
   );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way write-back/write-allocate cache, true-LRU; hit = 3 cycles/request, misses wait on mem_req_ready/mem_resp_valid.
// Single outstanding request (req_ready only in IDLE); CACHE_PERF_CNT_EN adds hit/miss counters.
`timescale 1ns/1ps
module set_assoc_cache #(
   parameter int WAYS       = 4,
   parameter int SETS       = 64,
   parameter int LINE_BYTES = 64,
   parameter int ADDR_BITS  = 32,
   parameter int WORD_BITS  = 32
) (
   input  logic             clk,
   input  logic             rst,
   set_assoc_cache_if.slave bus
);
   localparam int OFF    = $clog2(LINE_BYTES);
   localparam int IDX    = $clog2(SETS);
   localparam int TAG    = ADDR_BITS - IDX - OFF;
   localparam int LINE   = LINE_BYTES * 8;
   localparam int WBYTES = WORD_BITS / 8;
   localparam int WB     = $clog2(WBYTES);
   localparam int WSEL   = (OFF > WB) ? OFF - WB : 1;
   localparam int AW     = $clog2(WAYS);
   localparam int LA     = ADDR_BITS - OFF;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [LA-1:0]         r_laddr;
   logic [WSEL-1:0]       r_wsel;
   logic                  r_write;
   logic [WORD_BITS-1:0]  r_wdata;
   logic [WBYTES-1:0]     r_wstrb;
   logic                  r_refill_wait;
   logic [AW-1:0]         r_vic_way;
   logic [WORD_BITS-1:0]  r_resp_rdata;
   logic                  r_resp_hit;

   logic                  r_valid [WAYS][SETS];
   logic                  r_dirty [WAYS][SETS];
   logic [TAG-1:0]        r_tag   [WAYS][SETS];
   logic [AW-1:0]         r_age   [WAYS][SETS];
   logic [LINE-1:0]       r_data  [WAYS][SETS];

   logic [IDX-1:0]        w_idx;
   logic [TAG-1:0]        w_tag;
   logic                  w_hit;
   logic [AW-1:0]         w_hit_way;
   logic [AW-1:0]         w_vic_way;
   logic                  w_vic_dirty;
   logic [LINE-1:0]       w_hit_line, w_hit_new, w_fill_line;
   logic                  w_accept, w_lookup, w_hit_upd, w_install, w_lru_upd;
   logic [AW-1:0]         w_acc_way;
   logic                  w_req_ready, w_mem_req_valid, w_mem_req_write;
   logic [ADDR_BITS-1:0]  w_mem_req_addr;
   logic [LINE-1:0]       w_mem_wdata;

   function automatic logic [LINE-1:0] f_merge(input logic [LINE-1:0] line,
                                               input logic [WSEL-1:0] sel,
                                               input logic [WORD_BITS-1:0] wd,
                                               input logic [WBYTES-1:0] ws);
      logic [LINE-1:0] l;
      l = line;
      for (int b = 0; b < WBYTES; b++) begin
         if (ws[b]) l[int'(sel)*WORD_BITS + b*8 +: 8] = wd[b*8 +: 8];
      end
      return l;
   endfunction

   function automatic logic [WORD_BITS-1:0] f_word(input logic [LINE-1:0] line,
                                                   input logic [WSEL-1:0] sel);
      return line[int'(sel)*WORD_BITS +: WORD_BITS];
   endfunction

   assign w_idx = r_laddr[IDX-1:0];
   assign w_tag = r_laddr[IDX +: TAG];

   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = AW'(w);
         end
      end
   end

   // Oldest way is the fallback; any invalid way wins, lowest index first.
   always_comb begin
      w_vic_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_age[w][w_idx] == AW'(WAYS - 1)) w_vic_way = AW'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w][w_idx]) w_vic_way = AW'(w);
      end
   end

   assign w_vic_dirty = r_valid[w_vic_way][w_idx] && r_dirty[w_vic_way][w_idx];
   assign w_hit_line  = r_data[w_hit_way][w_idx];
   assign w_hit_new   = r_write ? f_merge(w_hit_line, r_wsel, r_wdata, r_wstrb) : w_hit_line;
   assign w_fill_line = r_write ? f_merge(bus.mem_rdata, r_wsel, r_wdata, r_wstrb) : bus.mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_accept        = 1'b0;
      w_lookup        = 1'b0;
      w_hit_upd       = 1'b0;
      w_install       = 1'b0;
      w_req_ready     = 1'b0;
      w_mem_req_valid = 1'b0;
      w_mem_req_write = 1'b0;
      w_mem_req_addr  = '0;
      w_mem_wdata     = '0;
      case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            w_lookup = 1'b1;
            if (w_hit) begin
               w_hit_upd   = 1'b1;
               w_state_nxt = S_RESPOND;
            end else if (w_vic_dirty) begin
               w_state_nxt = S_WRITEBACK;
            end else begin
               w_state_nxt = S_REFILL;
            end
         end
         S_WRITEBACK: begin
            w_mem_req_valid = 1'b1;
            w_mem_req_write = 1'b1;
            w_mem_req_addr  = {r_tag[r_vic_way][w_idx], w_idx, {OFF{1'b0}}};
            w_mem_wdata     = r_data[r_vic_way][w_idx];
            if (bus.mem_req_ready) w_state_nxt = S_REFILL;
         end
         S_REFILL: begin
            if (!r_refill_wait) begin
               w_mem_req_valid = 1'b1;
               w_mem_req_addr  = {r_laddr, {OFF{1'b0}}};
            end else if (bus.mem_resp_valid) begin
               w_install   = 1'b1;
               w_state_nxt = S_RESPOND;
            end
         end
         S_RESPOND: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_laddr <= bus.req_addr[ADDR_BITS-1:OFF];
         r_wsel  <= WSEL'(bus.req_addr[OFF-1:0] >> WB);
         r_write <= bus.req_write;
         r_wdata <= bus.req_wdata;
         r_wstrb <= bus.req_wstrb;
      end
      if (w_lookup && !w_hit) r_vic_way <= w_vic_way;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_refill_wait <= 1'b0;
         r_resp_rdata  <= '0;
         r_resp_hit    <= 1'b0;
      end else begin
         if (r_state == S_REFILL && !r_refill_wait && bus.mem_req_ready) r_refill_wait <= 1'b1;
         else if (w_install)                                             r_refill_wait <= 1'b0;
         if (w_hit_upd) begin
            r_resp_rdata <= f_word(w_hit_new, r_wsel);
            r_resp_hit   <= 1'b1;
         end else if (w_install) begin
            r_resp_rdata <= f_word(w_fill_line, r_wsel);
            r_resp_hit   <= 1'b0;
         end
      end
   end

   assign w_lru_upd = w_hit_upd | w_install;
   assign w_acc_way = w_install ? r_vic_way : w_hit_way;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               r_valid[w][s] <= 1'b0;
               r_dirty[w][s] <= 1'b0;
               r_age[w][s]   <= AW'(w);
            end
         end
      end else begin
         if (w_hit_upd && r_write) r_dirty[w_hit_way][w_idx] <= 1'b1;
         if (w_install) begin
            r_valid[r_vic_way][w_idx] <= 1'b1;
            r_dirty[r_vic_way][w_idx] <= r_write;
            r_tag[r_vic_way][w_idx]   <= w_tag;
         end
         // Ages younger than the accessed way shift up by one, keeping a permutation.
         if (w_lru_upd) begin
            for (int w = 0; w < WAYS; w++) begin
               if (AW'(w) == w_acc_way)
                  r_age[w][w_idx] <= '0;
               else if (r_age[w][w_idx] < r_age[w_acc_way][w_idx])
                  r_age[w][w_idx] <= r_age[w][w_idx] + AW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_hit_upd && r_write) r_data[w_hit_way][w_idx] <= w_hit_new;
         if (w_install)            r_data[r_vic_way][w_idx] <= w_fill_line;
      end
   end

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] r_hit_cnt, r_miss_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_lookup) begin
         if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
         else       r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign bus.hit_count  = r_hit_cnt;
   assign bus.miss_count = r_miss_cnt;
`else
   assign bus.hit_count  = '0;
   assign bus.miss_count = '0;
`endif

   assign bus.req_ready     = w_req_ready;
   assign bus.resp_valid    = (r_state == S_RESPOND);
   assign bus.resp_rdata    = r_resp_rdata;
   assign bus.resp_hit      = r_resp_hit;
   assign bus.mem_req_valid = w_mem_req_valid;
   assign bus.mem_req_write = w_mem_req_write;
   assign bus.mem_req_addr  = w_mem_req_addr;
   assign bus.mem_wdata     = w_mem_wdata;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed table of CPU requests against set_assoc_cache with a behavioural line memory,
// plus hand sequences for reset state, reset during refill and the perf counters.
`timescale 1ns/1ps
module tb_set_assoc_cache;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   set_assoc_cache_if #(.ADDR_BITS(32), .WORD_BITS(32), .LINE_BITS(512)) bus ();

   set_assoc_cache #(
      .WAYS(4), .SETS(64), .LINE_BYTES(64), .ADDR_BITS(32), .WORD_BITS(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [511:0] mem [logic [31:0]];

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          stall;
      logic        exp_hit;
      logic [31:0] exp_rdata;
      int          exp_wb;
      logic [31:0] exp_wb_addr;
      logic [31:0] exp_wb_w0;
   } vec_t;

   vec_t vecs[$];
   vec_t post[$];

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int stall, input logic hit,
                               input logic [31:0] rdata, input int wb, input logic [31:0] wb_addr,
                               input logic [31:0] wb_w0);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.stall = stall;
      v.exp_hit = hit; v.exp_rdata = rdata; v.exp_wb = wb;
      v.exp_wb_addr = wb_addr; v.exp_wb_w0 = wb_w0;
      return v;
   endfunction

   // Untouched memory holds each word's own byte address.
   function automatic logic [511:0] line_of(input logic [31:0] a);
      logic [511:0] l;
      if (mem.exists(a)) return mem[a];
      for (int k = 0; k < 16; k++) l[k*32 +: 32] = a + 32'(k*4);
      return l;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic apply(input string nm, input vec_t v);
      int c, nrd, nwb, stall_left, exp_lat;
      logic pend, first_seen;
      logic [31:0] pend_addr, wb_addr, wb_w0, first_addr;
      logic [511:0] first_wdata;
      nrd = 0; nwb = 0; stall_left = v.stall; pend = 1'b0; first_seen = 1'b0;
      pend_addr = '0; wb_addr = '0; wb_w0 = '0; first_addr = '0; first_wdata = '0;
      chk({nm, "_req_ready"}, bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_write = v.wr;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.req_wstrb = v.wstrb;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      c = 1;
      while (!bus.resp_valid && c < 200) begin
         bus.mem_req_ready  = 1'b0;
         bus.mem_resp_valid = 1'b0;
         if (pend) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = line_of(pend_addr);
            pend               = 1'b0;
         end else if (bus.mem_req_valid) begin
            if (stall_left > 0 && bus.mem_req_write) begin
               if (!first_seen) begin
                  first_seen  = 1'b1;
                  first_addr  = bus.mem_req_addr;
                  first_wdata = bus.mem_wdata;
               end else begin
                  chk({nm, "_stall_addr"}, bus.mem_req_addr, first_addr);
                  chk({nm, "_stall_wdata_same"}, 64'(bus.mem_wdata == first_wdata), 1);
               end
               stall_left--;
            end else begin
               bus.mem_req_ready = 1'b1;
               if (bus.mem_req_write) begin
                  nwb++;
                  wb_addr = bus.mem_req_addr;
                  wb_w0   = bus.mem_wdata[31:0];
                  mem[bus.mem_req_addr] = bus.mem_wdata;
               end else begin
                  nrd++;
                  pend      = 1'b1;
                  pend_addr = bus.mem_req_addr;
               end
            end
         end
         @(posedge clk); #1;
         c++;
      end
      chk({nm, "_resp_seen"}, bus.resp_valid, 1);
      exp_lat = v.exp_hit ? 2 : (4 + v.exp_wb + (v.exp_wb != 0 ? v.stall : 0));
      chk({nm, "_hit"}, bus.resp_hit, v.exp_hit);
      chk({nm, "_rdata"}, bus.resp_rdata, v.exp_rdata);
      chk({nm, "_refills"}, nrd, v.exp_hit ? 0 : 1);
      chk({nm, "_writebacks"}, nwb, v.exp_wb);
      chk({nm, "_latency"}, c, exp_lat);
      if (v.exp_wb != 0) begin
         chk({nm, "_wb_addr"}, wb_addr, v.exp_wb_addr);
         chk({nm, "_wb_word0"}, wb_w0, v.exp_wb_w0);
      end
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_resp_pulse"}, bus.resp_valid, 0);
      chk({nm, "_back_idle"}, bus.req_ready, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [511:0] l;
      int c;
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0;   bus.req_wstrb = '0;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
      l = line_of(32'h1000);
      l[31:0] = 32'hDEAD_BEEF;
      mem[32'h1000] = l;

      // set 0: refill, hit, partial store, fill all ways, dirty eviction, re-read of written-back line
      vecs.push_back(mk(0, 32'h1000, 0, 4'h0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0));
      vecs.push_back(mk(0, 32'h1000, 0, 4'h0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0));
      vecs.push_back(mk(1, 32'h1000, 32'h1234_5678, 4'h3, 0, 1, 32'hDEAD_5678, 0, 0, 0));
      vecs.push_back(mk(0, 32'h1000, 0, 4'h0, 0, 1, 32'hDEAD_5678, 0, 0, 0));
      vecs.push_back(mk(0, 32'h2004, 0, 4'h0, 0, 0, 32'h2004, 0, 0, 0));
      vecs.push_back(mk(0, 32'h3008, 0, 4'h0, 0, 0, 32'h3008, 0, 0, 0));
      vecs.push_back(mk(0, 32'h400C, 0, 4'h0, 0, 0, 32'h400C, 0, 0, 0));
      vecs.push_back(mk(0, 32'h5000, 0, 4'h0, 0, 0, 32'h5000, 1, 32'h1000, 32'hDEAD_5678));
      vecs.push_back(mk(0, 32'h1000, 0, 4'h0, 0, 0, 32'hDEAD_5678, 0, 0, 0));
      // set 1: ways 0..3, touch way 0, new tag must evict way 1
      vecs.push_back(mk(0, 32'h1040, 0, 4'h0, 0, 0, 32'h1040, 0, 0, 0));
      vecs.push_back(mk(0, 32'h2040, 0, 4'h0, 0, 0, 32'h2040, 0, 0, 0));
      vecs.push_back(mk(0, 32'h3040, 0, 4'h0, 0, 0, 32'h3040, 0, 0, 0));
      vecs.push_back(mk(0, 32'h4040, 0, 4'h0, 0, 0, 32'h4040, 0, 0, 0));
      vecs.push_back(mk(0, 32'h1040, 0, 4'h0, 0, 1, 32'h1040, 0, 0, 0));
      vecs.push_back(mk(0, 32'h6040, 0, 4'h0, 0, 0, 32'h6040, 0, 0, 0));
      vecs.push_back(mk(0, 32'h1040, 0, 4'h0, 0, 1, 32'h1040, 0, 0, 0));
      vecs.push_back(mk(0, 32'h2040, 0, 4'h0, 0, 0, 32'h2040, 0, 0, 0));
      vecs.push_back(mk(0, 32'h4040, 0, 4'h0, 0, 1, 32'h4040, 0, 0, 0));
      vecs.push_back(mk(0, 32'h3040, 0, 4'h0, 0, 0, 32'h3040, 0, 0, 0));
      // set 2: store-miss merge into refill, then dirty eviction with a 10-cycle stall
      vecs.push_back(mk(1, 32'h1080, 32'hAAAA_BBBB, 4'hC, 0, 0, 32'hAAAA_1080, 0, 0, 0));
      vecs.push_back(mk(0, 32'h2080, 0, 4'h0, 0, 0, 32'h2080, 0, 0, 0));
      vecs.push_back(mk(0, 32'h3080, 0, 4'h0, 0, 0, 32'h3080, 0, 0, 0));
      vecs.push_back(mk(0, 32'h4080, 0, 4'h0, 0, 0, 32'h4080, 0, 0, 0));
      vecs.push_back(mk(0, 32'h5080, 0, 4'h0, 10, 0, 32'h5080, 1, 32'h1080, 32'hAAAA_1080));

      // after the aborting reset: 3 misses then 5 hits
      post.push_back(mk(0, 32'h1000, 0, 4'h0, 0, 0, 32'hDEAD_5678, 0, 0, 0));
      post.push_back(mk(0, 32'h2000, 0, 4'h0, 0, 0, 32'h2000, 0, 0, 0));
      post.push_back(mk(0, 32'h3000, 0, 4'h0, 0, 0, 32'h3000, 0, 0, 0));
      post.push_back(mk(0, 32'h1000, 0, 4'h0, 0, 1, 32'hDEAD_5678, 0, 0, 0));
      post.push_back(mk(0, 32'h1004, 0, 4'h0, 0, 1, 32'h1004, 0, 0, 0));
      post.push_back(mk(0, 32'h2000, 0, 4'h0, 0, 1, 32'h2000, 0, 0, 0));
      post.push_back(mk(0, 32'h3000, 0, 4'h0, 0, 1, 32'h3000, 0, 0, 0));
      post.push_back(mk(0, 32'h2008, 0, 4'h0, 0, 1, 32'h2008, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_hit", bus.resp_hit, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_mem_req_valid", bus.mem_req_valid, 0);
      chk("rst_mem_req_write", bus.mem_req_write, 0);
      chk("rst_mem_req_addr", bus.mem_req_addr, 0);
      chk("rst_mem_wdata_zero", 64'(bus.mem_wdata == '0), 1);
      chk("rst_hit_count", bus.hit_count, 0);
      chk("rst_miss_count", bus.miss_count, 0);

      for (int i = 0; i < vecs.size(); i++) apply($sformatf("v%0d", i), vecs[i]);

      // reset while the refill request is still waiting for mem_req_ready
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h7000;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      c = 0;
      while (!(bus.mem_req_valid && !bus.mem_req_write) && c < 20) begin
         @(posedge clk); #1;
         c++;
      end
      chk("abort_refill_valid", bus.mem_req_valid, 1);
      chk("abort_refill_addr", bus.mem_req_addr, 32'h7000);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_mem_req_valid", bus.mem_req_valid, 0);
      chk("abort_req_ready", bus.req_ready, 1);
      chk("abort_resp_valid", bus.resp_valid, 0);
      chk("abort_miss_count", bus.miss_count, 0);

      for (int i = 0; i < post.size(); i++) apply($sformatf("p%0d", i), post[i]);

`ifdef CACHE_PERF_CNT_EN
      chk("perf_hit_count", bus.hit_count, 5);
      chk("perf_miss_count", bus.miss_count, 3);
`else
      chk("perf_hit_count", bus.hit_count, 0);
      chk("perf_miss_count", bus.miss_count, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
